ecg_sample_buffer: RTL
======================

# ecg_sample_buffer

Circular sample store that is the write end of the ECG sample-fetch path. It accepts digitised ECG samples over a valid/ready stream and writes them into a 2**ADDR_W-entry buffer. It also answers the fetch unit's address/strobe reads (12-bit `address` plus divided `clk_out`), returning the stored sample with a fixed latency. Unwritten locations always read as zero, so no memory clear is needed after reset.

## Interface
- `ADDR_W`, 12: address width; depth = 2**ADDR_W (4096).
- `DATA_W`, 12: sample width.
- `RING`, 1: 1 = overwrite oldest when full; 0 = stop accepting when full.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  DATA_W  incoming sample.
- `wr_valid`  in  1  sample present.
- `wr_ready`  out  1  buffer accepts a sample this cycle.
- `freeze`  in  1  level; blocks writes so the fetch side reads a stable snapshot.
- `rd_addr`  in  ADDR_W  fetch-unit address.
- `rd_clk`  in  1  fetch-unit divided clock, treated as data, not as a clock.
- `rd_data`  out  DATA_W  returned sample.
- `rd_valid`  out  1  one-cycle pulse when `rd_data` is updated.
- `wr_ptr`  out  ADDR_W  next write location.
- `count`  out  ADDR_W+1  samples stored, saturating at 2**ADDR_W.
- `wrapped`  out  1  sticky; `wr_ptr` has passed the top address at least once.
- `overflow`  out  1  sticky; a sample was dropped.

## Operation
- Write FSM states: EMPTY (count=0), FILL (0<count<DEPTH), FULL (count=DEPTH).
- `wr_ready` = !freeze && (state!=FULL || RING). A write occurs when `wr_valid && wr_ready`.
- On each write:
  - mem[wr_ptr] ← wr_data.
  - wr_ptr increments modulo 2**ADDR_W, wrapping 4095→0.
  - count increments, saturating at DEPTH.
- On the wrap 4095→0, `wrapped` is set and stays set until reset.
- State transitions:
  - EMPTY→FILL on the first write.
  - FILL→FULL on the write that makes count=DEPTH.
  - FULL holds until reset. With RING=1 it keeps writing, and count stays at DEPTH.
- `overflow` is set when `wr_valid && !wr_ready && !freeze`, i.e. a full, non-ring buffer is offered a sample. It stays set until reset. Stalls caused by `freeze` are not overflow.
- Read side:
  - `rd_clk` passes through a 2-flop synchroniser, then a third flop for edge detection.
  - `rd_addr` passes through a matching 2-flop stage.
  - A rising edge of the synchronised `rd_clk` latches the synchronised address into `addr_q`.
- Masking: if !wrapped and addr_q >= count (location never written), `rd_data` ← 0. Otherwise `rd_data` ← mem[addr_q].
- The memory is read-first: when a read and a write hit the same address in the same cycle, the read returns the old contents.
- The `rd_clk` falling edge has no effect. Read edges are processed independently of `freeze` and the write state.

## Timing
- Reset values (async, all outputs):
  - wr_ptr=0, count=0, state=EMPTY.
  - wr_ready = !freeze (combinational).
  - rd_data=0, rd_valid=0, wrapped=0, overflow=0.
  - Synchroniser and edge flops = 0; memory not cleared.
- Write latency: accepted at edge N. count, wr_ptr and state update at N+1, and the data is readable from N+1.
- Read latency:
  - `rd_clk` rises before edge N.
  - Edge detected at N+2 (after the synchroniser).
  - `addr_q` loaded at N+2.
  - `rd_data` updated and `rd_valid` high for exactly one cycle at N+3.
- `rd_addr` must be stable for at least 3 `clk` cycles around each `rd_clk` rising edge. `rd_clk` high and low phases must each be ≥ 2 `clk` cycles. Faster strobes may be missed and are not required to be counted.
- Reset asserted mid-read cancels any pending `rd_valid`. Reset asserted mid-stream drops the in-flight write.

## Test plan
- Reset, then write 0x001..0x00A with `rd_clk` toggled at `rd_addr`=3 → count=10, wr_ptr=10, state FILL. Read gives rd_data=0x004 with `rd_valid` exactly 3 cycles after the `rd_clk` rise.
- Read `rd_addr`=0x200 with count=10 → rd_data=0x000 (masked), `rd_valid` pulses once.
- RING=1: write 4100 samples (value = index) → wrapped=1, count=4096, wr_ptr=4; reading address 2 returns 4098 & 0xFFF.
- RING=0: write 4096 samples, then offer one more → wr_ready=0, overflow=1, mem[0] unchanged.
- Hold `freeze`=1 with `wr_valid`=1 for 20 cycles → no writes, overflow stays 0. Reads during the freeze still return data.
- Assert `rst` mid-stream and mid-read → all outputs at reset values on the next edge, no `rd_valid` pulse, and the prior contents read as 0.

Source files
------------

// File: rtl/ecg_sample_buffer.sv
// ecg_sample_buffer
// Circular ECG sample store. Samples arrive over a valid/ready stream and are
// written at wr_ptr. The fetch unit reads through a slow address/strobe pair
// (rd_addr plus its divided clock rd_clk). That pair is sampled as data,
// synchronised into clk, and answered with a fixed three-cycle latency.
// Any location that has not been written since reset reads back as zero, so
// the memory array itself never needs clearing.

module ecg_sample_buffer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter bit RING   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_clk,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   count,
    output logic              wrapped,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;

    // Count values in the count width. FULL is the saturation value.
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_TOP    = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Write FSM encoding.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // ------------------------------------------------------------------
    // Storage and write-side state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              wr_en_s;
    logic              drop_s;
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic [ADDR_W:0]   count_nxt_s;
    logic              wrap_now_s;

    // ------------------------------------------------------------------
    // Read-side synchroniser and pipeline
    // ------------------------------------------------------------------
    logic              rclk_s1_r;
    logic              rclk_s2_r;
    logic              rclk_s3_r;
    logic [ADDR_W-1:0] raddr_s1_r;
    logic [ADDR_W-1:0] raddr_s2_r;
    logic [ADDR_W-1:0] addr_q_r;
    logic              rd_pend_r;
    logic              rd_edge_s;
    logic              rd_mask_s;

    // Handshake: only a full, non-ring buffer or an active freeze stalls the writer.
    always_comb begin
        wr_ready = 1'b0;
        if (freeze) begin
            wr_ready = 1'b0;
        end else if ((state_r != ST_FULL) || RING) begin
            wr_ready = 1'b1;
        end else begin
            wr_ready = 1'b0;
        end
    end

    // Accept and drop qualifiers. A freeze stall is intentional, so it never counts as a drop.
    always_comb begin
        wr_en_s = wr_valid && wr_ready;
        drop_s  = wr_valid && !wr_ready && !freeze;
    end

    // Next pointer, saturating count and wrap detection for the current write.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr;
        count_nxt_s  = count;
        wrap_now_s   = 1'b0;
        if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr + PTR_ONE;
            wrap_now_s   = (wr_ptr == PTR_TOP);
            if (count != COUNT_FULL) begin
                count_nxt_s = count + COUNT_ONE;
            end else begin
                count_nxt_s = count;
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr;
            wrap_now_s   = 1'b0;
        end
    end

    // Write FSM next-state logic. FULL is terminal until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (wr_en_s) begin
                    state_nxt_s = (count == COUNT_LAST) ? ST_FULL : ST_FILL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FILL: begin
                if (wr_en_s && (count == COUNT_LAST)) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_FULL: begin
                state_nxt_s = ST_FULL;
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Write-side registers: FSM, pointer, count and the sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_EMPTY;
            wr_ptr   <= {ADDR_W{1'b0}};
            count    <= {(ADDR_W+1){1'b0}};
            wrapped  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wr_ptr  <= wr_ptr_nxt_s;
            count   <= count_nxt_s;
            if (wrap_now_s) begin
                wrapped <= 1'b1;
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // Sample array. It has no reset, because the read mask hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr] <= wr_data;
        end
    end

    // Fetch strobe and address synchronisers, plus the third flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rclk_s1_r  <= 1'b0;
            rclk_s2_r  <= 1'b0;
            rclk_s3_r  <= 1'b0;
            raddr_s1_r <= {ADDR_W{1'b0}};
            raddr_s2_r <= {ADDR_W{1'b0}};
        end else begin
            rclk_s1_r  <= rd_clk;
            rclk_s2_r  <= rclk_s1_r;
            rclk_s3_r  <= rclk_s2_r;
            raddr_s1_r <= rd_addr;
            raddr_s2_r <= raddr_s1_r;
        end
    end

    // Rising edge of the synchronised strobe. A falling edge has no effect.
    always_comb begin
        rd_edge_s = rclk_s2_r && !rclk_s3_r;
    end

    // Latch the fetch address on each strobe edge and flag a pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q_r  <= {ADDR_W{1'b0}};
            rd_pend_r <= 1'b0;
        end else begin
            rd_pend_r <= rd_edge_s;
            if (rd_edge_s) begin
                addr_q_r <= raddr_s2_r;
            end
        end
    end

    // Before the first wrap, only addresses below count have ever been written.
    always_comb begin
        rd_mask_s = 1'b0;
        if (!wrapped && ({1'b0, addr_q_r} >= count)) begin
            rd_mask_s = 1'b1;
        end else begin
            rd_mask_s = 1'b0;
        end
    end

    // Registered response. The array is read with the pre-edge contents,
    // so a same-cycle write to the same address returns the old sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= {DATA_W{1'b0}};
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_pend_r;
            if (rd_pend_r) begin
                rd_data <= rd_mask_s ? {DATA_W{1'b0}} : mem_r[addr_q_r];
            end
        end
    end

endmodule
